// File: rtl/demux_pkg.sv
// Shared types and sizing for the 1-to-4 stream demultiplexer.
package demux_pkg;

  typedef enum logic {IDLE, LOCK} demux_state_t;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

endpackage

// File: rtl/demux4_stream_if.sv
// Stream bundle for demux4_stream: one input stream fanned out to NUM_CH output slots.
interface demux4_stream_if
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        in_sel;
  logic [WIDTH-1:0]        in_data;
  logic                    in_last;
  logic [NUM_CH-1:0]       out_valid;
  logic [NUM_CH-1:0]       out_ready;
  logic [NUM_CH*WIDTH-1:0] out_data;
  logic [NUM_CH-1:0]       out_last;

  modport master (
    output in_valid, in_sel, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_sel, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/demux_slot.sv
// One-entry valid/ready register; a load in the same cycle as a drain keeps the slot full.
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             drain_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             last
);

  // Payload only changes on a load, so a stalled slot holds its data stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (valid && drain_ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux4_stream.sv
// Registered 1-to-4 stream demultiplexer with a packet lock so multi-beat packets stay on one channel.
module demux4_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  demux4_stream_if.slave  bus,
  output logic            busy
);

  demux_state_t         state;
  logic [SEL_W-1:0]     lock_sel;
  logic [SEL_W-1:0]     dest;
  logic                 accept;
  logic [NUM_CH-1:0]    slot_valid;
  logic [NUM_CH-1:0]    slot_last;
  logic [WIDTH-1:0]     slot_data [NUM_CH];

  assign dest         = (state == LOCK) ? lock_sel : bus.in_sel;
  assign bus.in_ready = !slot_valid[dest] || bus.out_ready[dest];
  assign accept       = bus.in_valid && bus.in_ready;

  // The first beat of a packet picks the channel; the lock holds it until in_last is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lock_sel <= '0;
      busy     <= 1'b0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          if (!bus.in_last) begin
            state    <= LOCK;
            lock_sel <= bus.in_sel;
            busy     <= 1'b1;
          end
        end
        LOCK: begin
          if (bus.in_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (accept && (dest == SEL_W'(k))),
      .load_data   (bus.in_data),
      .load_last   (bus.in_last),
      .drain_ready (bus.out_ready[k]),
      .valid       (slot_valid[k]),
      .data        (slot_data[k]),
      .last        (slot_last[k])
    );
    assign bus.out_data[k*WIDTH +: WIDTH] = slot_data[k];
  end

  assign bus.out_valid = slot_valid;
  assign bus.out_last  = slot_last;

endmodule

// File: tb/tb_demux4_stream.sv
// Self-checking bench for demux4_stream: directed vector table, hand sequences, and a queue-model random run.
module tb_demux4_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   n_checks = 0;
  int   n_errors = 0;

  demux4_stream_if #(.WIDTH(8)) bus ();

  demux4_stream #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] sel;
    logic [7:0] data;
    logic       last;
    logic [3:0] ordy;
    logic       exp_rdy;
    logic [3:0] exp_ov;
    logic       chk_data;
    logic [1:0] chk_ch;
    logic [7:0] exp_data;
    logic       exp_busy;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } beat_t;

  vec_t  vecs [9];
  beat_t mq [4][$];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [1:0] sel, input logic [7:0] data,
                                input logic last, input logic [3:0] ordy);
    bus.in_valid  = v;
    bus.in_sel    = sel;
    bus.in_data   = data;
    bus.in_last   = last;
    bus.out_ready = ordy;
  endtask

  function automatic logic [7:0] ch_data(input int k);
    return bus.out_data[k*8 +: 8];
  endfunction

  initial begin
    logic       m_lock;
    logic [1:0] m_ch;
    logic       v, last, exp_rdy;
    logic [1:0] sel, dst;
    logic [7:0] data;
    logic [3:0] ordy;

    // Directed vectors: single-beat packets to each channel, then a locked 3-beat packet.
    vecs[0] = '{1'b1, 2'd0, 8'h10, 1'b1, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10, 1'b0};
    vecs[1] = '{1'b1, 2'd1, 8'h11, 1'b1, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11, 1'b0};
    vecs[2] = '{1'b1, 2'd2, 8'h12, 1'b1, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12, 1'b0};
    vecs[3] = '{1'b1, 2'd3, 8'h13, 1'b1, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13, 1'b0};
    vecs[4] = '{1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0};
    vecs[5] = '{1'b1, 2'd2, 8'hA0, 1'b0, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA0, 1'b1};
    vecs[6] = '{1'b1, 2'd1, 8'hA1, 1'b0, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA1, 1'b1};
    vecs[7] = '{1'b1, 2'd3, 8'hA2, 1'b1, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2, 1'b0};
    vecs[8] = '{1'b0, 2'd0, 8'h00, 1'b0, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0};

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      apply_stimulus(1'($urandom), 2'($urandom), 8'($urandom), 1'($urandom), 4'($urandom));
      #1;
      check_output("rst_out_valid", 32'(bus.out_valid), 32'h0);
      check_output("rst_out_data", bus.out_data, 32'h0);
      check_output("rst_out_last", 32'(bus.out_last), 32'h0);
      check_output("rst_busy", 32'(busy), 32'h0);
      check_output("rst_in_ready", 32'(bus.in_ready), 32'h1);
    end
    @(negedge clk);
    apply_stimulus(1'b0, 2'd0, 8'h00, 1'b0, 4'hF);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("post_rst_busy", 32'(busy), 32'h0);
    check_output("post_rst_in_ready", 32'(bus.in_ready), 32'h1);

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      apply_stimulus(vecs[i].v, vecs[i].sel, vecs[i].data, vecs[i].last, vecs[i].ordy);
      #1;
      check_output($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk);
      #1;
      check_output($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_ov));
      check_output($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      if (vecs[i].chk_data)
        check_output($sformatf("vec%0d_data", i), 32'(ch_data(int'(vecs[i].chk_ch))), 32'(vecs[i].exp_data));
    end

    // Backpressure on channel 1: second beat waits, then loads as the first drains.
    @(negedge clk);
    apply_stimulus(1'b1, 2'd1, 8'h55, 1'b1, 4'b1101);
    #1;
    check_output("bp_first_ready", 32'(bus.in_ready), 32'h1);
    @(posedge clk);
    @(negedge clk);
    apply_stimulus(1'b1, 2'd1, 8'h66, 1'b1, 4'b1101);
    #1;
    check_output("bp_stall_ready", 32'(bus.in_ready), 32'h0);
    check_output("bp_stall_valid", 32'(bus.out_valid[1]), 32'h1);
    check_output("bp_stall_data", 32'(ch_data(1)), 32'h55);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      check_output("bp_hold_data", 32'(ch_data(1)), 32'h55);
      check_output("bp_hold_last", 32'(bus.out_last[1]), 32'h1);
      check_output("bp_hold_ready", 32'(bus.in_ready), 32'h0);
    end
    bus.out_ready = 4'hF;
    #1;
    check_output("bp_release_ready", 32'(bus.in_ready), 32'h1);
    @(posedge clk);
    #1;
    check_output("bp_swap_valid", 32'(bus.out_valid[1]), 32'h1);
    check_output("bp_swap_data", 32'(ch_data(1)), 32'h66);
    @(negedge clk);
    apply_stimulus(1'b0, 2'd0, 8'h00, 1'b0, 4'hF);
    @(posedge clk);
    #1;
    check_output("bp_drained", 32'(bus.out_valid), 32'h0);

    // Channel 0 stalled and full while channel 3 streams at full rate.
    @(negedge clk);
    apply_stimulus(1'b1, 2'd0, 8'h77, 1'b1, 4'b0000);
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      apply_stimulus(1'b1, 2'd3, 8'(8'h30 + i), 1'b1, 4'b1000);
      #1;
      check_output("ind_ready3", 32'(bus.in_ready), 32'h1);
      @(posedge clk);
      #1;
      check_output("ind_data3", 32'(ch_data(3)), 32'(8'h30 + i));
      check_output("ind_valid", 32'(bus.out_valid), 32'b1001);
      check_output("ind_data0", 32'(ch_data(0)), 32'h77);
    end
    @(negedge clk);
    apply_stimulus(1'b1, 2'd0, 8'h78, 1'b1, 4'b1000);
    #1;
    check_output("ind_ready0_blocked", 32'(bus.in_ready), 32'h0);
    apply_stimulus(1'b0, 2'd0, 8'h00, 1'b0, 4'hF);
    @(posedge clk);
    #1;
    check_output("ind_drained", 32'(bus.out_valid), 32'h0);

    // Reset in the middle of a sel=3 packet.
    @(negedge clk);
    apply_stimulus(1'b1, 2'd3, 8'hC0, 1'b0, 4'hF);
    @(posedge clk);
    @(negedge clk);
    apply_stimulus(1'b1, 2'd3, 8'hC1, 1'b0, 4'hF);
    @(posedge clk);
    #1;
    check_output("mid_busy", 32'(busy), 32'h1);
    check_output("mid_valid", 32'(bus.out_valid), 32'b1000);
    @(negedge clk);
    apply_stimulus(1'b0, 2'd0, 8'h00, 1'b0, 4'hF);
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    check_output("mid_rst_data", bus.out_data, 32'h0);
    check_output("mid_rst_busy", 32'(busy), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(1'b1, 2'd0, 8'h99, 1'b1, 4'hF);
    #1;
    check_output("after_rst_ready", 32'(bus.in_ready), 32'h1);
    @(posedge clk);
    #1;
    check_output("after_rst_valid", 32'(bus.out_valid), 32'b0001);
    check_output("after_rst_data", 32'(ch_data(0)), 32'h99);
    check_output("after_rst_busy", 32'(busy), 32'h0);

    // Random traffic against a per-channel queue model of the packet routing rules.
    @(negedge clk);
    rst_n = 1'b0;
    apply_stimulus(1'b0, 2'd0, 8'h00, 1'b0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    m_lock = 1'b0;
    m_ch   = 2'd0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      v    = ($urandom_range(0, 3) != 0);
      sel  = 2'($urandom);
      data = 8'($urandom);
      last = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < 4; k++) ordy[k] = ($urandom_range(0, 3) != 0);
      apply_stimulus(v, sel, data, last, ordy);
      #1;
      dst     = m_lock ? m_ch : sel;
      exp_rdy = (mq[dst].size() == 0) || ordy[dst];
      check_output("rnd_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      check_output("rnd_busy", 32'(busy), 32'(m_lock));
      for (int k = 0; k < 4; k++) begin
        check_output($sformatf("rnd_valid%0d", k), 32'(bus.out_valid[k]), 32'(mq[k].size() != 0));
        if (mq[k].size() != 0) begin
          check_output($sformatf("rnd_data%0d", k), 32'(ch_data(k)), 32'(mq[k][0].d));
          check_output($sformatf("rnd_last%0d", k), 32'(bus.out_last[k]), 32'(mq[k][0].l));
        end
      end
      @(posedge clk);
      for (int k = 0; k < 4; k++)
        if (mq[k].size() != 0 && ordy[k]) void'(mq[k].pop_front());
      if (v && exp_rdy) begin
        mq[dst].push_back('{d: data, l: last});
        if (!m_lock && !last) begin
          m_lock = 1'b1;
          m_ch   = sel;
        end else if (m_lock && last) begin
          m_lock = 1'b0;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
